// File: rtl/noc_packet_injector.sv
// NoC local-port injector: one command plus FLITS-1 payload words become HEAD, BODY..., TAIL flits at 1 flit/cycle.
// Flits are registered (1-cycle latency); cmd_ready/pl_ready fall whenever a held flit is stalled by ready_out.
module noc_packet_injector #(
  parameter int N          = 6,
  parameter int INDEX      = 0,
  parameter int DATA_WIDTH = 32,
  parameter int FLITS      = 6,
  localparam int DEST_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEST_W-1:0]     cmd_dest,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-3:0] pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  drop_pulse,
  output logic [7:0]            pkt_seq
);

  localparam int                CNT_W  = (FLITS > 2) ? $clog2(FLITS) : 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(FLITS - 2);
  localparam logic [DEST_W-1:0] SRC    = DEST_W'(INDEX);
  localparam logic [DEST_W:0]   N_L    = (DEST_W + 1)'(N);
  localparam logic [1:0]        T_HEAD = 2'b01;
  localparam logic [1:0]        T_BODY = 2'b10;
  localparam logic [1:0]        T_TAIL = 2'b11;

  typedef enum logic [1:0] {IDLE, PAYLD, DROP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              seq_q, seq_d;
  logic                    vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    drop_q, drop_d;
  logic [DATA_WIDTH-1:0]   head;
  logic                    adv;
  logic                    is_last;

  // The output register may be overwritten only when empty or draining this cycle.
  assign adv     = !vld_q || ready_out;
  assign is_last = (cnt_q == LAST);

  always_comb begin
    head = '0;
    head[DATA_WIDTH-1 -: 2]                = T_HEAD;
    head[DATA_WIDTH-3 -: DEST_W]           = cmd_dest;
    head[DATA_WIDTH-3-DEST_W -: DEST_W]    = SRC;
    head[DATA_WIDTH-3-2*DEST_W -: 8]       = seq_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    vld_d     = vld_q;
    dat_d     = dat_q;
    drop_d    = 1'b0;
    cmd_ready = 1'b0;
    pl_ready  = 1'b0;
    if (adv) vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = adv;
        if (cmd_valid && adv) begin
          cnt_d = '0;
          if ({1'b0, cmd_dest} < N_L) begin
            vld_d   = 1'b1;
            dat_d   = head;
            state_d = PAYLD;
          end else begin
            state_d = DROP;
          end
        end
      end
      PAYLD: begin
        pl_ready = adv;
        if (pl_valid && adv) begin
          vld_d = 1'b1;
          dat_d = {(is_last ? T_TAIL : T_BODY), pl_data};
          cnt_d = cnt_q + 1'b1;
          if (is_last) begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        // Discarded payload never touches the output register, so it is never back-pressured.
        pl_ready = 1'b1;
        if (pl_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (is_last) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst) begin
      cmd_ready = 1'b0;
      pl_ready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= 8'd0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      drop_q  <= drop_d;
    end
  end

  assign data_out   = dat_q;
  assign valid_out  = vld_q;
  assign drop_pulse = drop_q;
  assign pkt_seq    = seq_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Bench for noc_packet_injector (N=6, INDEX=2, 32-bit flits, 6 flits/packet): directed table,
// stall, drop, wrap, random and mid-packet reset sequences against a packet-level queue model.
module tb_noc_packet_injector;

  localparam int FLITS = 6;

  logic        clk, rst;
  logic [2:0]  cmd_dest;
  logic        cmd_valid, cmd_ready;
  logic [29:0] pl_data;
  logic        pl_valid, pl_ready;
  logic [31:0] data_out;
  logic        valid_out, ready_out;
  logic        drop_pulse;
  logic [7:0]  pkt_seq;

  noc_packet_injector #(.N(6), .INDEX(2), .DATA_WIDTH(32), .FLITS(FLITS)) dut (
    .clk(clk), .rst(rst),
    .cmd_dest(cmd_dest), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .drop_pulse(drop_pulse), .pkt_seq(pkt_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random, 3: left to caller
  int last_cmd_cyc = 0;
  int last_word_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_head(input logic [2:0] d, input logic [7:0] s);
    return {2'b01, d, 3'd2, s, 16'h0000};
  endfunction

  // Packet-level reference: each output flit the injector owes the router, in order.
  typedef enum {M_IDLE, M_PAY, M_DROP} mph_t;
  logic [31:0] mq[$];
  mph_t        mph = M_IDLE;
  int          mwords = 0;
  logic [7:0]  mseq = 8'd0;
  bit          exp_drop = 1'b0;
  bit          prev_rst = 1'b1;
  int          xfers = 0;
  int          drops = 0;

  always @(negedge clk) begin
    bit adv;
    if (!rst) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_pl_ready", 32'(pl_ready), 32'd0);
      if (!prev_rst) begin
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_pkt_seq", 32'(pkt_seq), 32'd0);
      end
      mq.delete();
      mph = M_IDLE; mwords = 0; mseq = 8'd0; exp_drop = 1'b0;
    end else begin
      adv = !valid_out || ready_out;
      chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("data_out", data_out, mq[0]);
      chk("cmd_ready", 32'(cmd_ready), 32'(mph == M_IDLE && adv));
      chk("pl_ready", 32'(pl_ready), 32'((mph == M_PAY && adv) || mph == M_DROP));
      chk("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
      chk("pkt_seq", 32'(pkt_seq), 32'(mseq));
      exp_drop = 1'b0;
      if (valid_out && ready_out) begin
        xfers++;
        if (mq.size() != 0) void'(mq.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        mwords = 0;
        if (cmd_dest < 3'd6) begin
          mq.push_back(mk_head(cmd_dest, mseq));
          mph = M_PAY;
        end else begin
          mph = M_DROP;
        end
      end
      if (pl_valid && pl_ready) begin
        mwords++;
        if (mph == M_PAY) mq.push_back({(mwords == FLITS - 1) ? 2'b11 : 2'b10, pl_data});
        if (mwords == FLITS - 1) begin
          if (mph == M_PAY) mseq = mseq + 8'd1;
          else begin exp_drop = 1'b1; drops++; end
          mph = M_IDLE;
        end
      end
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0: ready_out = 1'b1;
      1: ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
      2: ready_out = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    pl_valid  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_dest  = 3'($urandom);
      pl_valid  = 1'($urandom_range(0, 1));
      pl_data   = 30'($urandom);
      ready_out = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i > 0) begin
        chk("reset_hold_valid", 32'(valid_out), 32'd0);
        chk("reset_hold_data", data_out, 32'd0);
        chk("reset_hold_seq", 32'(pkt_seq), 32'd0);
        chk("reset_hold_rdys", 32'({cmd_ready, pl_ready, drop_pulse}), 32'd0);
      end
      tick();
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    pl_valid  = 1'b0;
  endtask

  task automatic send_pkt(input logic [2:0] dest, input logic [29:0] base, input bit rnd);
    bit fired;
    int to;
    fired = 1'b0; to = 0;
    while (!fired && to < 100) begin
      cmd_dest  = dest;
      cmd_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pl_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      pl_data   = 30'($urandom);
      @(negedge clk);
      fired = cmd_valid && cmd_ready;
      if (fired) last_cmd_cyc = cyc;
      tick();
      to++;
    end
    chk("cmd_handshake", 32'(fired), 32'd1);
    for (int w = 0; w < FLITS - 1; w++) begin
      fired = 1'b0; to = 0;
      while (!fired && to < 100) begin
        cmd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_dest  = 3'($urandom);
        pl_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        pl_data   = rnd ? 30'($urandom) : base + 30'(w);
        @(negedge clk);
        fired = pl_valid && pl_ready;
        if (fired) last_word_cyc = cyc;
        tick();
        to++;
      end
      chk("pl_handshake", 32'(fired), 32'd1);
    end
    cmd_valid = 1'b0;
    pl_valid  = 1'b0;
  endtask

  typedef struct {
    logic        cmd_v;
    logic [2:0]  dest;
    logic        pl_v;
    logic [29:0] pl;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_crdy;
    logic        e_prdy;
    logic [7:0]  e_seq;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d limit=30000", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int x0, n, t0;
    logic [7:0] pre_seq;
    rst = 1'b0; cmd_valid = 1'b0; cmd_dest = '0; pl_valid = 1'b0; pl_data = '0; ready_out = 1'b0;

    tbl[0] = '{1'b1, 3'd4, 1'b0, 30'd0, 1'b1, 1'b0, 32'h0,           1'b1, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 3'd0, 1'b1, 30'd1, 1'b1, 1'b1, mk_head(3'd4, 8'd0), 1'b0, 1'b1, 8'd0};
    tbl[2] = '{1'b0, 3'd0, 1'b1, 30'd2, 1'b1, 1'b1, 32'h8000_0001,   1'b0, 1'b1, 8'd0};
    tbl[3] = '{1'b0, 3'd0, 1'b1, 30'd3, 1'b1, 1'b1, 32'h8000_0002,   1'b0, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 3'd0, 1'b1, 30'd4, 1'b1, 1'b1, 32'h8000_0003,   1'b0, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 3'd0, 1'b1, 30'd5, 1'b1, 1'b1, 32'h8000_0004,   1'b0, 1'b1, 8'd0};
    tbl[6] = '{1'b0, 3'd0, 1'b0, 30'd0, 1'b1, 1'b1, 32'hC000_0005,   1'b1, 1'b0, 8'd1};
    tbl[7] = '{1'b0, 3'd0, 1'b0, 30'd0, 1'b1, 1'b0, 32'h0,           1'b1, 1'b0, 8'd1};

    do_reset(3);

    rdy_mode = 3;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = tbl[i].cmd_v; cmd_dest = tbl[i].dest;
      pl_valid  = tbl[i].pl_v;  pl_data  = tbl[i].pl;
      ready_out = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_data", i), data_out, tbl[i].e_dat);
      chk($sformatf("tbl%0d_cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_crdy));
      chk($sformatf("tbl%0d_pl_ready", i), 32'(pl_ready), 32'(tbl[i].e_prdy));
      chk($sformatf("tbl%0d_seq", i), 32'(pkt_seq), 32'(tbl[i].e_seq));
      tick();
    end

    rdy_mode = 1;
    x0 = xfers;
    send_pkt(3'd4, 30'd1, 1'b0);
    idle(8);
    chk("stall_xfers", 32'(xfers - x0), 32'd6);

    rdy_mode = 0;
    pre_seq = mseq;
    x0 = xfers; n = drops;
    send_pkt(3'd7, 30'd20, 1'b0);
    idle(3);
    chk("drop_xfers", 32'(xfers - x0), 32'd0);
    chk("drop_count", 32'(drops - n), 32'd1);
    chk("drop_seq", 32'(pkt_seq), 32'(pre_seq));
    x0 = xfers;
    send_pkt(3'd3, 30'd40, 1'b0);
    idle(3);
    chk("after_drop_xfers", 32'(xfers - x0), 32'd6);

    do_reset(2);
    rdy_mode = 0;
    t0 = 0;
    for (int i = 0; i < 257; i++) begin
      send_pkt(3'(i % 6), 30'(i * 8), 1'b0);
      if (i == 0) t0 = last_cmd_cyc;
    end
    chk("b2b_cycles", 32'(last_word_cyc - t0), 32'(257 * FLITS - 1));
    idle(3);
    chk("wrap_seq", 32'(pkt_seq), 32'd1);

    rdy_mode = 2;
    for (int i = 0; i < 60; i++) send_pkt(3'($urandom_range(0, 7)), 30'd0, 1'b1);
    rdy_mode = 0;
    idle(6);
    chk("random_drained", 32'(mq.size()), 32'd0);

    rdy_mode = 0;
    cmd_valid = 1'b1; cmd_dest = 3'd4; pl_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      @(negedge clk);
      if (valid_out && ready_out) n++;
      tick();
      cmd_valid = 1'b0;
      pl_valid  = 1'b1;
      pl_data   = 30'(k + 50);
    end
    chk("midrst_xfers", 32'(n), 32'd3);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    pl_valid = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_seq", 32'(pkt_seq), 32'd0);
    tick();
    send_pkt(3'd1, 30'd70, 1'b0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
